// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that time-shares the 32-bit seven-segment value among NUM_REQ requesters.
// Optional macro SEG_ARB_TAG_EN: forces val_out[31:28] to the owner index.
module seg_display_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [32*NUM_REQ-1:0]      val_in,
  output logic [NUM_REQ-1:0]         ack_out,
  output logic [31:0]                val_out,
  output logic [$clog2(NUM_REQ)-1:0] src_out,
  output logic                       valid_out,
  output logic                       busy_out
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        val_q, val_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic [31:0]        slice [NUM_REQ];
  logic               found;
  logic [SRC_W-1:0]   win;
  logic [SRC_W:0]     cand;
  logic               load;
  logic [SRC_W-1:0]   load_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = val_in[32*g +: 32];
  end

  // Search starts one past the last grant; the extra bit absorbs the wrap
  // so non-power-of-two NUM_REQ works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      if (!found && req_in[cand[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    val_d        = val_q;
    src_d        = src_q;
    valid_d      = valid_q;
    ack_d        = '0;
    load         = 1'b0;
    load_idx     = src_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = SHOW;
          cnt_d        = '0;
          src_d        = win;
          last_grant_d = win;
          valid_d      = 1'b1;
          ack_d[win]   = 1'b1;
          load         = 1'b1;
          load_idx     = win;
        end
      end
      SHOW: begin
        cnt_d = cnt_q + 32'd1;
        if (req_in[src_q]) begin
          load     = 1'b1;
          load_idx = src_q;
        end
        if (cnt_q == 32'(DWELL_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      val_d = slice[load_idx];
`ifdef SEG_ARB_TAG_EN
      val_d[31:28] = 4'(load_idx);
`endif
    end

    busy_d = (state_d == SHOW);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      val_q        <= '0;
      src_q        <= '0;
      valid_q      <= 1'b0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      val_q        <= val_d;
      src_q        <= src_d;
      valid_q      <= valid_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
    end
  end

  assign ack_out   = ack_q;
  assign val_out   = val_q;
  assign src_out   = src_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (NUM_REQ=4, DWELL_CYCLES=8) against
// a cycle-level behavioural model of the arbitration rules.
module tb_seg_display_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [31:0]       v [NREQ];
  logic [32*NREQ-1:0] val_flat;
  logic [NREQ-1:0]   ack_out;
  logic [31:0]       val_out;
  logic [1:0]        src_out;
  logic              valid_out;
  logic              busy_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model state
  bit          m_show;
  int          m_left;
  int          m_last;
  int          m_src;
  logic [31:0] m_val;
  bit          m_valid;
  logic [3:0]  m_ack;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) val_flat[32*i +: 32] = v[i];
  end

  seg_display_arbiter #(.NUM_REQ(NREQ), .DWELL_CYCLES(DWELL)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .req_in   (req),
    .val_in   (val_flat),
    .ack_out  (ack_out),
    .val_out  (val_out),
    .src_out  (src_out),
    .valid_out(valid_out),
    .busy_out (busy_out)
  );

  function automatic logic [31:0] tagv(input logic [31:0] x, input int owner);
    logic [31:0] r;
    r = x;
`ifdef SEG_ARB_TAG_EN
    r[31:28] = 4'(owner);
`endif
    return r;
  endfunction

  function automatic logic [39:0] dut_o();
    return {ack_out, val_out, src_out, valid_out, busy_out};
  endfunction

  function automatic logic [39:0] mdl_o();
    return {m_ack, m_val, 2'(m_src), m_valid, m_show};
  endfunction

  // Advance the model on the current inputs, then let the DUT take the same edge.
  task automatic step();
    bit got;
    int c;
    if (rst) begin
      m_show = 0; m_left = 0; m_last = NREQ - 1; m_src = 0;
      m_val = '0; m_valid = 0; m_ack = '0;
    end else if (!m_show) begin
      m_ack = '0;
      got = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!got && req[c]) begin
          got = 1;
          m_show = 1; m_left = DWELL; m_src = c; m_last = c;
          m_val = tagv(v[c], c); m_valid = 1; m_ack = 4'(1 << c);
        end
      end
    end else begin
      m_ack = '0;
      if (req[m_src]) m_val = tagv(v[m_src], m_src);
      m_left--;
      if (m_left == 0) m_show = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    for (int i = 0; i < NREQ; i++) v[i] = $urandom;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (dut_o() !== 40'h0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got ack=%b val=%h src=%0d valid=%b busy=%b want all zero",
                 cyc, ack_out, val_out, src_out, valid_out, busy_out);
      end
      v[n % NREQ] = $urandom;
      step();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int busy_run;
    v[0] = 32'h1111_1111; v[1] = 32'h2222_2222;
    v[2] = 32'h3333_3333; v[3] = 32'h4444_4444;
    req = 4'b1111;
    busy_run = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (dut_o() !== mdl_o()) begin
        failures++;
        $display("FAIL rr_outputs cycle=%0d got=%h want=%h", cyc, dut_o(), mdl_o());
      end
      if (ack_out != 0) begin
        for (int i = 0; i < NREQ; i++) if (ack_out[i]) order.push_back(i);
      end
      if (busy_out) busy_run++;
      else if (busy_run != 0) begin
        checks++;
        if (busy_run != DWELL) begin
          failures++;
          $display("FAIL rr_busy_len got=%0d want=%0d", busy_run, DWELL);
        end
        busy_run = 0;
      end
    end
    checks++;
    if (order.size() != 5) begin
      failures++;
      $display("FAIL rr_grant_count got=%0d want=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_live_track();
    int acks[$];
    logic [31:0] prev;
    do_reset();
    req = 4'b0100;
    v[2] = $urandom;
    for (int n = 0; n < 40; n++) begin
      prev = v[2];
      step();
      v[2] = v[2] + 32'd1;
      checks++;
      if (dut_o() !== mdl_o()) begin
        failures++;
        $display("FAIL live_outputs cycle=%0d got=%h want=%h", cyc, dut_o(), mdl_o());
      end
      checks++;
      if (val_out !== tagv(prev, 2)) begin
        failures++;
        $display("FAIL live_lag cycle=%0d got=%h want=%h", cyc, val_out, tagv(prev, 2));
      end
      if (ack_out == 4'b0100) acks.push_back(cyc);
    end
    checks++;
    if (acks.size() != 5) begin
      failures++;
      $display("FAIL live_ack_count got=%0d want=5", acks.size());
    end
    for (int i = 1; i < acks.size(); i++) begin
      checks++;
      if (acks[i] - acks[i-1] != DWELL + 1) begin
        failures++;
        $display("FAIL live_ack_period got=%0d want=%0d", acks[i] - acks[i-1], DWELL + 1);
      end
    end
  endtask

  task automatic test_drop_hold();
    logic [31:0] frozen;
    do_reset();
    req = 4'b1010;
    v[1] = $urandom; v[3] = $urandom;
    step();
    frozen = '0;
    for (int k = 0; k <= 9; k++) begin
      checks++;
      if (dut_o() !== mdl_o()) begin
        failures++;
        $display("FAIL drop_outputs k=%0d got=%h want=%h", k, dut_o(), mdl_o());
      end
      if (k == 0 || k == 9) begin
        checks++;
        if (ack_out !== (k == 0 ? 4'b0010 : 4'b1000)) begin
          failures++;
          $display("FAIL drop_ack k=%0d got=%b want=%b", k, ack_out, (k == 0 ? 4'b0010 : 4'b1000));
        end
      end else begin
        checks++;
        if (ack_out !== 4'b0000) begin
          failures++;
          $display("FAIL drop_no_ack k=%0d got=%b want=0000", k, ack_out);
        end
      end
      if (k >= 3 && k <= 8) begin
        checks++;
        if (val_out !== tagv(frozen, 1)) begin
          failures++;
          $display("FAIL drop_frozen k=%0d got=%h want=%h", k, val_out, tagv(frozen, 1));
        end
      end
      if (k == 2) frozen = v[1];
      req = (k < 2) ? 4'b1010 : 4'b1000;
      if (k < 2) v[1] = $urandom;
      else if (k > 2) v[1] = $urandom;
      step();
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    req = 4'b1010;
    v[1] = $urandom; v[3] = $urandom;
    step();
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (busy_out !== 1'b1 || src_out !== 2'd1) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b src=%0d want busy=1 src=1", busy_out, src_out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dut_o() !== 40'h0) begin
      failures++;
      $display("FAIL midrst_values got=%h want=0", dut_o());
    end
    step();
    checks++;
    if (ack_out !== 4'b0010 || src_out !== 2'd1 || busy_out !== 1'b1 || val_out !== tagv(v[1], 1)) begin
      failures++;
      $display("FAIL midrst_regrant got ack=%b src=%0d busy=%b val=%h want ack=0010 src=1 busy=1 val=%h",
               ack_out, src_out, busy_out, val_out, tagv(v[1], 1));
    end
  endtask

  task automatic test_tag();
    logic [31:0] want;
`ifdef SEG_ARB_TAG_EN
    want = 32'h2FFF_FFFF;
`else
    want = 32'hFFFF_FFFF;
`endif
    do_reset();
    req = 4'b0100;
    v[2] = 32'hFFFF_FFFF;
    step();
    checks++;
    if (val_out !== want || ack_out !== 4'b0100) begin
      failures++;
      $display("FAIL tag_value got val=%h ack=%b want val=%h ack=0100", val_out, ack_out, want);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) v[i] = $urandom;
      step();
      checks++;
      if (dut_o() !== mdl_o()) begin
        failures++;
        $display("FAIL random_outputs cycle=%0d got=%h want=%h", cyc, dut_o(), mdl_o());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) v[i] = '0;
    test_reset();
    test_round_robin();
    test_live_track();
    test_drop_hold();
    test_reset_mid_show();
    test_tag();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the 32-bit, 8-digit seven-segment display value among NUM_REQ independent requesters. Arbitration is round-robin, and each grant is held for a guaranteed minimum dwell time. The block sits between debug/status producers and the seven-segment controller's 32-bit value input. While its grant is active, a requester's value is shown live. Once the requester drops its request, the last value shown is held.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DWELL_CYCLES, 100_000_000: minimum SHOW duration in clk_in cycles; must be ≥ 2.
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- req_in  input  NUM_REQ  per-requester display request; level-sensitive.
- val_in  input  32*NUM_REQ  flattened values; requester i occupies bits [32*i+31:32*i].
- ack_out  output  NUM_REQ  one-cycle grant pulse to the winning requester.
- val_out  output  32  value to the seven-segment controller.
- src_out  output  $clog2(NUM_REQ)  index of the current or last owner.
- valid_out  output  1  high once any grant has occurred since reset.
- busy_out  output  1  high while in SHOW.

## Operation
- State machine has two states: IDLE and SHOW.
- Registered state:
  - last_grant pointer, $clog2(NUM_REQ) bits.
  - dwell counter, 32 bits.
  - val_out, src_out, valid_out, ack_out.
- IDLE:
  - No req_in bit high: remain in IDLE, and all outputs hold.
  - Any req_in bit high: the winner is the first requester with req high, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - On the next edge:
    - state goes to SHOW, and the dwell counter is set to 0.
    - val_out takes the winner's val_in slice; src_out and last_grant take the winner index.
    - ack_out has only the winner's bit set, and valid_out goes to 1.
- SHOW:
  - The dwell counter increments every cycle.
  - If req_in[src_out] is high, val_out takes val_in[src_out] each cycle (live tracking).
  - If req_in[src_out] is low, val_out holds.
  - When the counter equals DWELL_CYCLES-1, the next edge returns to IDLE. SHOW therefore lasts exactly DWELL_CYCLES cycles.
- No preemption: other requests wait for the dwell to expire, whatever happens to the owner's request.
- Owner as sole requester at dwell expiry: it is re-granted after one IDLE cycle, and receives a new ack pulse.
- ack_out is zero in every cycle other than the cycle that enters SHOW.
- In IDLE, val_out and src_out keep the last owner's data. The display never blanks after the first grant.
- Reset mid-SHOW: the dwell is aborted and all registers return to their reset values on that edge. The arbiter restarts with requester 0 as highest priority.

## Timing
- Reset values:
  - state IDLE; last_grant NUM_REQ-1; counter 0.
  - val_out 32'h0, src_out 0, ack_out 0, valid_out 0, busy_out 0.
- Grant latency: req_in sampled high in IDLE at edge t gives ack_out, busy_out and the new val_out visible after edge t, i.e. in cycle t+1.
- Re-arbitration gap: exactly one IDLE cycle between consecutive SHOW periods when requests are pending.
- Live-tracking latency: one cycle from val_in to val_out.
- busy_out is a registered decode of state.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro SEG_ARB_TAG_EN. Purpose: shows which requester is being displayed.
- SEG_ARB_TAG_EN defined:
  - val_out[31:28] is forced to the zero-extended owner index, covering both the ack cycle and live tracking.
  - Bits [27:0] carry the requester value, so the leftmost digit shows the source.
- SEG_ARB_TAG_EN not defined:
  - All 32 bits pass through unmodified.
  - The reset value remains 32'h0 in both cases.

## Test plan
Bench parameters: NUM_REQ=4, DWELL_CYCLES=8.

1. Reset, then req_in=4'b0000 for 20 cycles -> valid_out=0, val_out=0, ack_out=0, busy_out=0 throughout.
2. req_in=4'b1111, val_in slices 32'h1111_1111 / 2222_2222 / 3333_3333 / 4444_4444 -> grant order 0,1,2,3,0. Each ack_out is a single-cycle pulse. busy_out is high for 8 cycles, then low for 1, between grants.
3. req_in[2] alone is held high, with val_in[2] incremented every cycle -> val_out follows val_in[2] one cycle late. Re-ack of requester 2 occurs every 9 cycles.
4. Requester 1 is granted and drops req at dwell cycle 3 while req[3] is high -> val_out freezes at its last value. Requester 3 is not acked until cycle 9 after the grant.
5. rst_in is asserted at dwell cycle 4 with req_in=4'b1010 -> the next cycle shows reset values. Requester 1 is granted before requester 3 after release.
6. With SEG_ARB_TAG_EN defined, requester 2 sends val 32'hFFFF_FFFF -> val_out=32'h2FFF_FFFF. Without the macro, val_out=32'hFFFF_FFFF.
